// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch stage
package fetch_pkg;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    typedef enum logic {RUN, HALT} fetch_state_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } slot_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: valid/ready slot handshake between fetch and decode
interface fetch_if #(parameter int A_WIDTH = 32);
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_instr;
    logic [A_WIDTH-1:0] out_pc;
    logic [A_WIDTH-1:0] out_pc_plus4;
    logic               out_fault;
    modport master (
        output out_valid, out_instr, out_pc, out_pc_plus4, out_fault,
        input  out_ready
    );
    modport slave (
        input  out_valid, out_instr, out_pc, out_pc_plus4, out_fault,
        output out_ready
    );
endinterface

// File: rtl/fetch_slot.sv
// fetch_slot: one-entry instruction register with load/flush/hold controls
module fetch_slot
    import fetch_pkg::*;
#(
    parameter int A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [31:0]        load_instr,
    input  logic [A_WIDTH-1:0] load_pc,
    input  logic               load_fault,
    output logic               valid,
    output logic [31:0]        instr,
    output logic [A_WIDTH-1:0] pc,
    output logic               fault
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
            fault <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
            fault <= load_fault;
        end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, ROM window check and RUN/HALT control feeding a one-entry decode slot
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 A_WIDTH      = 32,
    parameter logic [A_WIDTH-1:0] RESET_VECTOR = A_WIDTH'(DEF_RESET_VECTOR),
    parameter int                 ROM_BYTES    = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               redirect_valid,
    input  logic [A_WIDTH-1:0] redirect_target,
    fetch_if.master            dec
);
    localparam logic [A_WIDTH-1:0] LAST = RESET_VECTOR + A_WIDTH'(ROM_BYTES - 4);
    fetch_state_t       state, state_next;
    logic [A_WIDTH-1:0] pc, pc_next;
    logic               advance, fault_now, load, flush;
    logic [31:0]        load_instr;
    assign advance    = !dec.out_valid || dec.out_ready;
    assign fault_now  = pc[1:0] != 2'b00 || pc < RESET_VECTOR || pc > LAST;
    assign load_instr = fault_now ? NOP_INSTR : imem_data;
    assign imem_addr  = pc;
    assign dec.out_pc_plus4 = dec.out_pc + A_WIDTH'(4);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= RUN;
            pc    <= RESET_VECTOR;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    // A faulting fetch parks the PC on the bad address until a redirect arrives
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        flush      = 1'b0;
        if (redirect_valid) begin
            pc_next    = redirect_target;
            flush      = 1'b1;
            state_next = RUN;
        end else if (advance) begin
            load  = state == RUN;
            flush = state == HALT;
            if (state == RUN) begin
                pc_next    = fault_now ? pc : pc + A_WIDTH'(4);
                state_next = fault_now ? HALT : RUN;
            end
        end
    end
    fetch_slot #(.A_WIDTH(A_WIDTH)) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .flush      (flush),
        .load_instr (load_instr),
        .load_pc    (pc),
        .load_fault (fault_now),
        .valid      (dec.out_valid),
        .instr      (dec.out_instr),
        .pc         (dec.out_pc),
        .fault      (dec.out_fault)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a per-cycle reference model of the fetch stage
module tb_fetch_unit;
    import fetch_pkg::*;
    localparam logic [31:0] RV = 32'hBFC00000;
    localparam int ROM_BYTES = 4096;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr, imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] rom [0:1023];
    fetch_if #(.A_WIDTH(32)) dec ();
    fetch_unit #(.A_WIDTH(32), .RESET_VECTOR(RV), .ROM_BYTES(ROM_BYTES)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .dec             (dec)
    );
    always #5 clk = ~clk;
    assign imem_data = rom[imem_addr[11:2]];
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    logic [31:0] delivered [$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic bit in_rom(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(RV);
        return a % 4 == 0 && off >= 0 && off < ROM_BYTES;
    endfunction
    // Reference model: what the slot and PC must hold after each edge
    logic [31:0] m_pc = RV;
    logic        m_valid = 1'b0;
    logic        m_halt = 1'b0;
    slot_t       m_slot = '{NOP_INSTR, 32'h0, 1'b0};
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_pc    <= RV;
            m_valid <= 1'b0;
            m_halt  <= 1'b0;
            m_slot  <= '{NOP_INSTR, 32'h0, 1'b0};
        end else if (redirect_valid) begin
            m_pc    <= redirect_target;
            m_valid <= 1'b0;
            m_halt  <= 1'b0;
        end else if (!m_valid || dec.out_ready) begin
            if (m_halt) m_valid <= 1'b0;
            else if (in_rom(m_pc)) begin
                m_slot  <= '{rom[10'((m_pc - RV) >> 2)], m_pc, 1'b0};
                m_valid <= 1'b1;
                m_pc    <= m_pc + 32'd4;
            end else begin
                m_slot  <= '{NOP_INSTR, m_pc, 1'b1};
                m_valid <= 1'b1;
                m_halt  <= 1'b1;
            end
        end
    always @(posedge clk)
        if (rst_n && dec.out_valid && dec.out_ready) delivered.push_back(dec.out_pc);
    always @(negedge clk)
        if (chk_en && rst_n) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("out_valid", dec.out_valid, m_valid);
            if (m_valid) begin
                chk("out_instr", dec.out_instr, m_slot.instr);
                chk("out_pc", dec.out_pc, m_slot.pc);
                chk("out_pc_plus4", dec.out_pc_plus4, m_slot.pc + 32'd4);
                chk("out_fault", dec.out_fault, m_slot.fault);
            end
        end
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask
    task automatic redirect(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
        step(1);
        redirect_valid = 1'b0;
    endtask
    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h00000093 | (i << 20);
        rom[0] = 32'h00500093;
        rom[1] = 32'h00100113;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        logic [15:0] pat;
        pat = 16'b1011001011100101;
        dec.out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_imem_addr", imem_addr, 32'hBFC00000);
        chk("rst_valid", dec.out_valid, 0);
        chk("rst_instr", dec.out_instr, 32'h00000013);
        chk("rst_pc", dec.out_pc, 0);
        chk("rst_pc_plus4", dec.out_pc_plus4, 4);
        chk("rst_fault", dec.out_fault, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        step(1);
        chk("first_pc", dec.out_pc, 32'hBFC00000);
        chk("first_instr", dec.out_instr, 32'h00500093);
        step(1);
        chk("second_pc", dec.out_pc, 32'hBFC00004);
        chk("second_instr", dec.out_instr, 32'h00100113);
        do_reset();
        dec.out_ready = 1'b0;
        delivered.delete();
        step(4);
        chk("stall_pc", dec.out_pc, 32'hBFC00000);
        chk("stall_addr", imem_addr, 32'hBFC00004);
        dec.out_ready = 1'b1;
        step(2);
        chk("resume_pc", dec.out_pc, 32'hBFC00008);
        chk("delivered_n", delivered.size(), 2);
        if (delivered.size() == 2) begin
            chk("delivered_0", delivered[0], 32'hBFC00000);
            chk("delivered_1", delivered[1], 32'hBFC00004);
        end
        redirect(32'hBFC00100);
        chk("redir_valid", dec.out_valid, 0);
        chk("redir_addr", imem_addr, 32'hBFC00100);
        step(1);
        chk("redir_pc", dec.out_pc, 32'hBFC00100);
        chk("redir_instr", dec.out_instr, 32'h04000093);
        redirect(32'hBFC00102);
        step(1);
        chk("misal_fault", dec.out_fault, 1);
        chk("misal_instr", dec.out_instr, 32'h00000013);
        chk("misal_pc", dec.out_pc, 32'hBFC00102);
        step(3);
        chk("halt_valid", dec.out_valid, 0);
        chk("halt_addr", imem_addr, 32'hBFC00102);
        redirect(32'hBFC00000);
        step(1);
        chk("rerun_pc", dec.out_pc, 32'hBFC00000);
        chk("rerun_fault", dec.out_fault, 0);
        redirect(32'hBFC00FF8);
        step(2);
        chk("last_pc", dec.out_pc, 32'hBFC00FFC);
        chk("last_instr", dec.out_instr, 32'h3FF00093);
        chk("last_fault", dec.out_fault, 0);
        step(1);
        chk("end_pc", dec.out_pc, 32'hBFC01000);
        chk("end_fault", dec.out_fault, 1);
        redirect(32'hFFFFFFFC);
        step(1);
        chk("top_fault", dec.out_fault, 1);
        chk("top_plus4", dec.out_pc_plus4, 32'h00000000);
        redirect(32'hBFBFFFFC);
        step(1);
        chk("below_fault", dec.out_fault, 1);
        redirect(RV);
        for (int i = 0; i < 16; i++) begin
            dec.out_ready   = pat[i];
            redirect_valid  = i == 9;
            redirect_target = RV + 32'h20;
            step(1);
        end
        redirect_valid = 1'b0;
        dec.out_ready  = 1'b1;
        step(2);
        chk("pre_arst_valid", dec.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", dec.out_valid, 0);
        chk("arst_addr", imem_addr, 32'hBFC00000);
        chk("arst_instr", dec.out_instr, 32'h00000013);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1);
        chk("post_arst_pc", dec.out_pc, 32'hBFC00000);
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
